// File: rtl/counter_nd.sv
// counter_nd: N-dimensional nested counter with per-axis run-time limits.
// Axis 0 is the fastest; each higher axis advances when every lower axis rolls over.
// Supports up/down counting, synchronous clear and a one-shot mode with a sticky done flag.
module counter_nd #(
  parameter int unsigned NDIM = 2,
  parameter int unsigned W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              dir_i,
  input  logic              oneshot_i,
  input  logic [NDIM*W-1:0] limit_i,
  output logic [NDIM*W-1:0] count_o,
  output logic [NDIM-1:0]   wrap_o,
  output logic              last_o,
  output logic              done_o
);

  // Per-axis views of the flat limit and count buses; axis i sits at [i*W +: W].
  logic [NDIM-1:0][W-1:0] lim;
  logic [NDIM-1:0][W-1:0] cnt_q, cnt_d;
  logic                   done_q, done_d;

  logic [NDIM-1:0] term;
  logic [NDIM:0]   carry;
  logic            step;
  logic            complete;

  assign lim = limit_i;

  // Terminal test per axis; up uses >= so a lowered limit ends the axis at once.
  always_comb begin
    term = '0;
    for (int i = 0; i < NDIM; i++) begin
      if (dir_i) begin
        term[i] = (cnt_q[i] == '0);
      end else begin
        term[i] = (cnt_q[i] >= lim[i]);
      end
    end
  end

  assign step = en_i && !done_q && !clr_i;

  // Ripple carry: an axis advances only when all lower axes are terminal.
  // carry[i+1] doubles as the wrap strobe of axis i.
  always_comb begin
    carry    = '0;
    carry[0] = step;
    for (int i = 0; i < NDIM; i++) begin
      carry[i+1] = carry[i] && term[i];
    end
  end

  assign last_o   = &term;
  assign wrap_o   = carry[NDIM:1];
  assign complete = oneshot_i && step && last_o;

  // Next-state per axis: clear, one-shot hold, wrap to start, step, or hold.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NDIM; i++) begin
      if (clr_i) begin
        cnt_d[i] = dir_i ? lim[i] : '0;
      end else if (complete) begin
        cnt_d[i] = cnt_q[i];
      end else if (carry[i+1]) begin
        cnt_d[i] = dir_i ? lim[i] : '0;
      end else if (carry[i]) begin
        cnt_d[i] = dir_i ? (cnt_q[i] - W'(1)) : (cnt_q[i] + W'(1));
      end
    end
  end

  // Sticky completion flag; only clear or reset releases it.
  always_comb begin
    done_d = done_q;
    if (clr_i) begin
      done_d = 1'b0;
    end else if (complete) begin
      done_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign count_o = cnt_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_counter_nd.sv
// Self-checking bench for counter_nd with NDIM=2, W=4, limits (axis1, axis0) = (2, 3).
module tb_counter_nd;

  localparam int unsigned NDIM = 2;
  localparam int unsigned W    = 4;

  logic             clk;
  logic             rst_n;
  logic             en_i, clr_i, dir_i, oneshot_i;
  logic [NDIM*W-1:0] limit_i;
  logic [NDIM*W-1:0] count_o;
  logic [NDIM-1:0]   wrap_o;
  logic              last_o;
  logic              done_o;

  counter_nd #(.NDIM(NDIM), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (en_i),
    .clr_i    (clr_i),
    .dir_i    (dir_i),
    .oneshot_i(oneshot_i),
    .limit_i  (limit_i),
    .count_o  (count_o),
    .wrap_o   (wrap_o),
    .last_o   (last_o),
    .done_o   (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en, clr, dir, os;
    logic [3:0] l1, l0;
    logic [1:0] wrap;
    logic       last;
    logic [3:0] c1, c0;
    logic       done;
  } vec_t;

  typedef struct {
    logic [3:0] c1, c0;
    logic       done;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   vec_no = 0;

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s vec %0d: got %h, expected %h", name, idx, act, req);
  endtask

  task automatic add(input logic en, input logic clr, input logic dir, input logic os,
                     input logic [3:0] l1, input logic [3:0] l0, input logic [1:0] wrap,
                     input logic last, input logic [3:0] c1, input logic [3:0] c0,
                     input logic done);
    vec_t v;
    v.en = en; v.clr = clr; v.dir = dir; v.os = os; v.l1 = l1; v.l0 = l0;
    v.wrap = wrap; v.last = last; v.c1 = c1; v.c0 = c0; v.done = done;
    vecs.push_back(v);
  endtask

  // Apply queued vectors: drive at negedge, check combinational outputs, then
  // check registered outputs after the following rising edge via the scoreboard.
  task automatic run_vecs();
    vec_t v;
    exp_t e;
    while (vecs.size() > 0) begin
      v = vecs.pop_front();
      @(negedge clk);
      en_i = v.en; clr_i = v.clr; dir_i = v.dir; oneshot_i = v.os;
      limit_i = {v.l1, v.l0};
      #1;
      chk("wrap", vec_no, {6'd0, wrap_o}, {6'd0, v.wrap});
      chk("last", vec_no, {7'd0, last_o}, {7'd0, v.last});
      e.c1 = v.c1; e.c0 = v.c0; e.done = v.done; e.idx = vec_no;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("count", e.idx, count_o, {e.c1, e.c0});
      chk("done", e.idx, {7'd0, done_o}, {7'd0, e.done});
      vec_no++;
    end
    en_i = 1'b0; clr_i = 1'b0;
  endtask

  initial begin
    int cur, nxt;
    en_i = 0; clr_i = 0; dir_i = 0; oneshot_i = 0; limit_i = {4'd2, 4'd3};
    rst_n = 0;
    #12;
    chk("rst_count", -1, count_o, 8'h00);
    chk("rst_done", -1, {7'd0, done_o}, 8'd0);
    chk("rst_wrap", -1, {6'd0, wrap_o}, 8'd0);
    chk("rst_last", -1, {7'd0, last_o}, 8'd0);
    rst_n = 1;

    // Up, wrap mode: 13 steps through the 12-state nest.
    for (int k = 0; k < 13; k++) begin
      cur = k % 12; nxt = (k + 1) % 12;
      add(1, 0, 0, 0, 2, 3, {cur == 11, (cur % 4) == 3}, cur == 11,
          4'(nxt / 4), 4'(nxt % 4), 0);
    end
    // Enable gaps starting from (0,2).
    add(0, 1, 0, 0, 2, 3, 2'b00, 0, 0, 0, 0);
    add(1, 0, 0, 0, 2, 3, 2'b00, 0, 0, 1, 0);
    add(1, 0, 0, 0, 2, 3, 2'b00, 0, 0, 2, 0);
    add(1, 0, 0, 0, 2, 3, 2'b00, 0, 0, 3, 0);
    add(0, 0, 0, 0, 2, 3, 2'b00, 0, 0, 3, 0);
    add(0, 0, 0, 0, 2, 3, 2'b00, 0, 0, 3, 0);
    add(1, 0, 0, 0, 2, 3, 2'b01, 0, 1, 0, 0);
    // Limit lowered mid-run at (0,3).
    add(0, 1, 0, 0, 2, 3, 2'b00, 0, 0, 0, 0);
    add(1, 0, 0, 0, 2, 3, 2'b00, 0, 0, 1, 0);
    add(1, 0, 0, 0, 2, 3, 2'b00, 0, 0, 2, 0);
    add(1, 0, 0, 0, 2, 3, 2'b00, 0, 0, 3, 0);
    add(1, 0, 0, 0, 2, 1, 2'b01, 0, 1, 0, 0);
    // Down: clear loads limits, then a full 12-step lap back to (2,3).
    add(0, 1, 1, 0, 2, 3, 2'b00, 0, 2, 3, 0);
    for (int v = 11; v >= 0; v--) begin
      nxt = (v == 0) ? 11 : v - 1;
      add(1, 0, 1, 0, 2, 3, {v == 0, (v % 4) == 0}, v == 0, 4'(nxt / 4), 4'(nxt % 4), 0);
    end
    // One-shot: run to (2,3), complete, then ignore further steps.
    add(0, 1, 0, 1, 2, 3, 2'b00, 1, 0, 0, 0);
    for (int k = 0; k < 11; k++) begin
      add(1, 0, 0, 1, 2, 3, {1'b0, (k % 4) == 3}, 0, 4'((k + 1) / 4), 4'((k + 1) % 4), 0);
    end
    add(1, 0, 0, 1, 2, 3, 2'b11, 1, 2, 3, 1);
    add(1, 0, 0, 1, 2, 3, 2'b00, 1, 2, 3, 1);
    add(1, 0, 0, 1, 2, 3, 2'b00, 1, 2, 3, 1);
    add(1, 0, 0, 0, 2, 3, 2'b00, 1, 2, 3, 1);
    add(0, 1, 0, 0, 2, 3, 2'b00, 1, 0, 0, 0);
    // Walk to (1,2) ahead of the asynchronous reset.
    for (int k = 0; k < 6; k++) begin
      add(1, 0, 0, 0, 2, 3, {1'b0, (k % 4) == 3}, 0, 4'((k + 1) / 4), 4'((k + 1) % 4), 0);
    end
    run_vecs();
    chk("pre_rst_count", -2, count_o, 8'h12);

    // Asynchronous reset between edges must clear state before the next edge.
    @(negedge clk);
    en_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", -3, count_o, 8'h00);
    chk("async_rst_done", -3, {7'd0, done_o}, 8'd0);
    en_i = 1'b0;
    #1 rst_n = 1'b1;

    // Clear and enable together at (1,1): clear wins and wrap stays low.
    for (int k = 0; k < 5; k++) begin
      add(1, 0, 0, 0, 2, 3, {1'b0, (k % 4) == 3}, 0, 4'((k + 1) / 4), 4'((k + 1) % 4), 0);
    end
    add(1, 1, 0, 0, 2, 3, 2'b00, 0, 0, 0, 0);
    // Axis 0 limit of zero: always terminal, passes every carry through.
    add(0, 1, 0, 0, 2, 0, 2'b00, 0, 0, 0, 0);
    add(1, 0, 0, 0, 2, 0, 2'b01, 0, 1, 0, 0);
    add(1, 0, 0, 0, 2, 0, 2'b01, 0, 2, 0, 0);
    add(1, 0, 0, 0, 2, 0, 2'b11, 1, 0, 0, 0);
    run_vecs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/counter_nd.md
# counter_nd

Parametrised N-dimensional nested counter, generalising the single-axis wrap counter to `NDIM` cascaded axes with run-time per-axis limits, up/down direction, synchronous clear and a one-shot mode. Axis 0 is the fastest; each higher axis advances when every lower axis rolls over. It drives raster/scan address generation in the 2D counting datapath. Per-axis wrap strobes and an all-axes `last` flag go to downstream control.

## Interface
- `NDIM`, default 2: number of axes, at least 1.
- `W`, default 16: width of each axis counter in bits.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: request one step of the nest.
- `clr`  in  1: synchronous clear to start values; also clears `done`.
- `dir`  in  1: 0 counts up, 1 counts down.
- `oneshot`  in  1: 0 wraps forever; 1 stops at the end of the nest.
- `limit`  in  NDIM*W: maximum value per axis; axis i is `limit[i*W +: W]`. Sampled live every cycle.
- `count`  out  NDIM*W: current value per axis; axis i is `count[i*W +: W]`.
- `wrap`  out  NDIM: axis i rolls over on this step.
- `last`  out  1: every axis is at its terminal value.
- `done`  out  1: sticky flag; the one-shot nest has completed.

## Operation
- Start and terminal values per axis:
  - Up: start 0, terminal when `count[i] >= limit[i]`. The `>=` test keeps a limit lowered mid-run from causing a 2^W-long run.
  - Down: start `limit[i]`, terminal when `count[i] == 0`.
- `step = en && !done && !clr`.
- Carry chain:
  - `carry_in[0] = step`.
  - `carry_in[i+1] = carry_in[i] && term[i]`.
- `wrap[i] = carry_in[i] && term[i]`, combinational.
- `last` = AND of all `term[i]`, combinational and independent of `en`.
- Axis update on the edge:
  - If `wrap[i]`, load the start value. In one-shot completion, hold instead (see below).
  - Else if `carry_in[i]`, add 1 (up) or subtract 1 (down), modulo 2^W.
  - Otherwise hold.
- One-shot completion, when `oneshot && step && last`:
  - All `wrap` bits assert as normal.
  - All axes hold their terminal values.
  - `done` sets on the edge.
- While `done=1`:
  - `en` is ignored, `wrap=0`, counts hold.
  - Only `clr` or reset leaves this state.
  - Deasserting `oneshot` while `done=1` has no effect until `clr`.
- `clr` has priority over `en`:
  - Loads start values for the current `dir` and `limit`.
  - Clears `done`.
  - Forces `wrap=0` that cycle.
- Changing `dir` mid-run: counting continues from the current value in the new direction. The terminal test uses the new `dir` immediately.
- `limit[i]=0`: axis i is always terminal and stays at 0. It passes every carry through, and `wrap[i]` equals `carry_in[i]`.
- Down mode with `count[i] > limit[i]` after a limit change: the axis decrements normally to 0. No clamping.
- Reset while counting: all state clears immediately, whatever the phase.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - `count` = 0 on every axis, `done=0`.
  - `wrap` and `last` follow combinationally from those values. With `limit=0` or `dir=1`, `last` can read 1 out of reset.
- Down mode after reset: counts are at 0, so every axis is terminal. The first step wraps all axes to their limits, so use `clr` to start cleanly.
- Latency:
  - `count` updates on the rising edge that samples `en=1`.
  - `wrap` and `last` are valid in the same cycle as `en`, with zero latency.
  - `done` asserts one cycle after the completing step.
- Combinational path: `wrap[NDIM-1]` depends on all axis comparators, i.e. NDIM comparators plus an AND chain. Register it downstream if timing is tight.
- No handshake: `en` may be held high for back-to-back steps or pulsed with arbitrary gaps. Counts hold during gaps.

## Test plan
All scenarios use `NDIM=2`, `W=4`, limits (axis1, axis0) = (2, 3).
- **Up, wrap mode:** reset, then 13 consecutive `en` pulses. Required response:
  - Counts run (0,0)…(0,3),(1,0)…(2,3),(0,0), i.e. (axis1, axis0).
  - `wrap[0]=1` at every axis0 value of 3.
  - `wrap=2'b11` and `last=1` at (2,3).
- **Enable gaps:** `en` toggles 1,0,0,1 starting at (0,2). Required response: count holds at (0,3) through the gap, then steps to (1,0) with `wrap[0]=1` on the second `en`.
- **Down:** `dir=1`, `clr` pulse. Required response:
  - Count reads (2,3), then steps (2,2),(2,1),(2,0),(1,3).
  - `wrap[0]=1` on the step from (2,0).
  - At (0,0), `last=1`, and the next step gives (2,3) with `wrap=2'b11`.
- **One-shot:** `oneshot=1`, up, run to (2,3), then apply one more `en`. Required response:
  - `wrap=2'b11` on that step; `done=1` next cycle; count stays at (2,3).
  - 3 further `en` pulses: no change and `wrap=0`.
  - `clr`: count (0,0), `done=0`.
- **Limit lowered mid-run:** at count (0,3), set axis0 limit to 1 and apply `en`. Required response: `term[0]` holds because 3 >= 1, so the count steps to (1,0) with `wrap[0]=1`.
- **Async reset mid-count, with `clr` and `en` collision:**
  - At (1,2), pulse `rst_n` low between edges. Required response: count reads (0,0) before the next edge and `done=0`.
  - Later, assert `clr` and `en` together at (1,1). Required response: count (0,0) and `wrap=0`.
